memory_cycle: RTL
=================

# memory_cycle

Pipeline memory (M) stage, directly downstream of the execute stage. It consumes the EX/M register outputs and performs loads and stores through a ready/request handshake with the L1 data cache controller. It asserts `StallM` to the hazard unit while a cache access is outstanding. It registers the M/W pipeline state that feeds the writeback stage and the forwarding paths.

## Interface
Parameters:
- `XLEN`, 32: data and address width.
- `CNT_W`, 32: width of the performance counters.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `RegwriteM`  in  1: register-write enable of the instruction in M.
- `MemwriteM`  in  1: store.
- `ResultSrcM`  in  2: result select; `2'b01` marks a load.
- `RdM`  in  5: destination register.
- `ALUResultM`  in  XLEN: effective address or ALU result.
- `WriteDataM`  in  XLEN: store data.
- `pc_plus4M`  in  XLEN: link value.
- `cache_req`  out  1: access request to L1.
- `cache_we`  out  1: 1 = write.
- `cache_addr`  out  XLEN: word-aligned address `{ALUResultM[XLEN-1:2],2'b00}`.
- `cache_wdata`  out  XLEN: equals `WriteDataM`.
- `cache_ready`  in  1: L1 completes the access this cycle; read data valid.
- `cache_rdata`  in  XLEN: load data.
- `StallM`  out  1: hold the PC, IF/ID, ID/EX and EX/M registers.
- `RegwriteW`, `ResultSrcW`(2), `RdW`(5), `ALUResultW`, `ReadDataW`, `pc_plus4W`  out: M/W register.
- `misalignedW`  out  1: the registered access had `ALUResultM[1:0] != 0`.
- `access_cnt`, `stall_cnt`  out  CNT_W: performance counters.

## Operation
- `mem_op = MemwriteM | (ResultSrcM == 2'b01)`.
- The FSM has two states, IDLE and WAIT.
- Request: `cache_req = (IDLE & mem_op) | WAIT`. `cache_we = MemwriteM`. The address and data are held stable by the upstream stall.
- `StallM = cache_req & ~cache_ready`. This is combinational, so a same-cycle hit costs no stall.
- IDLE with `mem_op` and not `cache_ready` goes to WAIT. WAIT goes to IDLE on `cache_ready`. All other cases hold state.
- The M/W register loads when `StallM == 0`:
  - `RegwriteW <= RegwriteM`; all other M fields are copied.
  - `ReadDataW <= cache_rdata` on a load. Otherwise `ReadDataW` holds its previous value.
- When `StallM == 1`, a bubble is inserted:
  - `RegwriteW <= 0` and `RdW <= 0`.
  - The other W fields hold.
- No access is re-issued after completion. The EX/M register advances on the same edge, so a new instruction is presented in M the next cycle.
- `access_cnt` increments on each completed access (`cache_req & cache_ready`). `stall_cnt` increments on each cycle with `StallM`. Both wrap modulo 2^CNT_W.
- Misaligned addresses are not trapped. The access proceeds to the aligned word and `misalignedW` is flagged.

## Timing
- Reset (`rst` low, asynchronous):
  - The state goes to IDLE.
  - All W outputs are 0, `misalignedW` is 0, and both counters are 0.
  - `cache_req`, `cache_we` and `StallM` are forced to 0 combinationally while `rst` is low, including a reset taken in WAIT mid-access. The L1 must treat a dropped `cache_req` as an abort.
- Latency:
  - Non-memory instruction: 1 cycle in M.
  - Hit with `cache_ready` in the request cycle: 1 cycle.
  - Miss completing N cycles after the request: N+1 cycles in M, with `StallM` high for N cycles.
- `cache_ready` is ignored while `cache_req` is low.
- Back-to-back memory operations: the second request is asserted in the cycle immediately after the first completes.
- A store followed by a load to the same address must return the stored data. This is an L1 responsibility; the stage imposes no ordering beyond in-order issue.

## Structure
- Shared package `pipe_pkg`:
  - FSM state encoding (`MEM_IDLE`, `MEM_WAIT`).
  - `RESULT_SRC_LOAD = 2'b01`.
  - `XLEN` default.
- One sub-module, `mem_req_fsm`, holds the state register, `cache_req`/`StallM` generation and the counters. The M/W register stays in `memory_cycle`.

## Test plan
- ALU op (`RegwriteM=1`, `RdM=5`, `ALUResultM=0x1234`), no memory access → next cycle `RegwriteW=1`, `RdW=5`, `ALUResultW=0x1234`, `StallM=0`, `cache_req=0`.
- Load at `0x100`, `cache_ready` in the same cycle with `cache_rdata=0xDEADBEEF` → no stall, next cycle `ReadDataW=0xDEADBEEF`, `access_cnt=1`.
- Store at `0x204`, data `0xA5A5A5A5`, `cache_ready` 3 cycles after the request → `StallM` high for 3 cycles, `cache_we=1`, `cache_wdata=0xA5A5A5A5` stable throughout, `RegwriteW=0` during the stall, `stall_cnt=3`.
- Misaligned load at `0x103` → `cache_addr=0x100` and `misalignedW=1`.
- Reset asserted in WAIT → `cache_req`/`StallM` drop immediately; after release the state is IDLE and the counters are 0.
- Two back-to-back loads, both hits → two completions on consecutive cycles, `access_cnt=2`, no stall.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the memory stage: request FSM states and
// the result-select code that marks a load.
package pipe_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_e;

endpackage

// File: rtl/mem_req_fsm.sv
// Cache request sequencer for the M stage: tracks an outstanding L1 access,
// raises the stall, and keeps access/stall performance counters.
//
//   state    | meaning
//   MEM_IDLE | no access outstanding; a new mem op requests immediately
//   MEM_WAIT | request issued, holding it until L1 returns cache_ready
module mem_req_fsm
  import pipe_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_op,
  input  logic             cache_ready,
  output logic             cache_req,
  output logic             StallM,
  output logic [CNT_W-1:0] access_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  mem_state_e r_state;
  mem_state_e w_next;
  logic       w_req;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= MEM_IDLE;
      access_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      r_state <= w_next;
      if (w_req && cache_ready) access_cnt <= access_cnt + 1'b1;
      if (w_req && !cache_ready) stall_cnt <= stall_cnt + 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    w_req  = 1'b0;
    case (r_state)
      MEM_IDLE: begin
        w_req = mem_op;
        if (mem_op && !cache_ready) w_next = MEM_WAIT;
      end
      MEM_WAIT: begin
        w_req = 1'b1;
        if (cache_ready) w_next = MEM_IDLE;
      end
      default: w_next = MEM_IDLE;
    endcase
  end

  // Dropping the request during reset tells L1 to abort an in-flight access.
  assign cache_req = rst & w_req;
  assign StallM    = cache_req & ~cache_ready;

endmodule

// File: rtl/memory_cycle.sv
// Pipeline memory stage: issues loads/stores to L1 through mem_req_fsm and
// registers the M/W state consumed by writeback and forwarding.
module memory_cycle
  import pipe_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             RegwriteM,
  input  logic             MemwriteM,
  input  logic [1:0]       ResultSrcM,
  input  logic [4:0]       RdM,
  input  logic [XLEN-1:0]  ALUResultM,
  input  logic [XLEN-1:0]  WriteDataM,
  input  logic [XLEN-1:0]  pc_plus4M,
  output logic             cache_req,
  output logic             cache_we,
  output logic [XLEN-1:0]  cache_addr,
  output logic [XLEN-1:0]  cache_wdata,
  input  logic             cache_ready,
  input  logic [XLEN-1:0]  cache_rdata,
  output logic             StallM,
  output logic             RegwriteW,
  output logic [1:0]       ResultSrcW,
  output logic [4:0]       RdW,
  output logic [XLEN-1:0]  ALUResultW,
  output logic [XLEN-1:0]  ReadDataW,
  output logic [XLEN-1:0]  pc_plus4W,
  output logic             misalignedW,
  output logic [CNT_W-1:0] access_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  logic w_is_load;
  logic w_mem_op;

  assign w_is_load = (ResultSrcM == RESULT_SRC_LOAD);
  assign w_mem_op  = MemwriteM | w_is_load;

  mem_req_fsm #(.CNT_W(CNT_W)) u_req_fsm (
    .clk        (clk),
    .rst        (rst),
    .mem_op     (w_mem_op),
    .cache_ready(cache_ready),
    .cache_req  (cache_req),
    .StallM     (StallM),
    .access_cnt (access_cnt),
    .stall_cnt  (stall_cnt)
  );

  assign cache_we    = rst & MemwriteM;
  assign cache_addr  = {ALUResultM[XLEN-1:2], 2'b00};
  assign cache_wdata = WriteDataM;

  // Stalled cycles emit a bubble; non-control fields hold for forwarding.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegwriteW   <= 1'b0;
      ResultSrcW  <= '0;
      RdW         <= '0;
      ALUResultW  <= '0;
      ReadDataW   <= '0;
      pc_plus4W   <= '0;
      misalignedW <= 1'b0;
    end else if (StallM) begin
      RegwriteW <= 1'b0;
      RdW       <= '0;
    end else begin
      RegwriteW   <= RegwriteM;
      ResultSrcW  <= ResultSrcM;
      RdW         <= RdM;
      ALUResultW  <= ALUResultM;
      pc_plus4W   <= pc_plus4M;
      misalignedW <= w_mem_op & (ALUResultM[1:0] != 2'b00);
      if (w_is_load) ReadDataW <= cache_rdata;
    end
  end

endmodule
